fetch_seq_ctrl: RTL and testbench

Front-end sequencing controller for the fetch pipeline. It owns the fetch PC and drives the per-stage STALL and FLUSH controls of the two front-end pipeline registers (D1 = first IF/ID stage, D2 = second stage feeding decode). It arbitrates between four sources: branch-mispredict redirect from EX, a decode hold request, instruction-cache miss, and the predictor's taken/target hint. It also keeps stall/flush performance counters and a sticky miss-timeout flag.

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/sat_counter.sv | 35 +++
 rtl/fetch_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch front-end sequencer: state encodings,
// the NOP pattern loaded on flush and the default boot address.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MISS    = 2'd1,
    ST_RECOVER = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC advances to 0.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Synchronous clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Front-end sequencer: owns the fetch PC and drives Mealy stall/flush controls
// for the IF stage and the D1/D2 pipeline registers; keeps perf counters.
module fetch_seq_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          MISS_TIMEOUT = 64,
  parameter int          CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IMISS,
  input  logic             IREADY,
  input  logic             ID_STALL,
  input  logic             MISPREDICT,
  input  logic [31:0]      CORRECT_PC,
  input  logic             PRED_TAKEN,
  input  logic [31:0]      PRED_TARGET,
  output logic [31:0]      FETCH_PC,
  output logic             STALL_IF,
  output logic             STALL_D1,
  output logic             STALL_D2,
  output logic             FLUSH_D1,
  output logic             FLUSH_D2,
  output logic [1:0]       STATE,
  output logic             MISS_ERR,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int            MW        = $clog2(MISS_TIMEOUT + 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_TIMEOUT - 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          ready_pend_q, ready_pend_d;
  logic          miss_err_q, miss_err_d;
  logic [MW-1:0] miss_cnt;
  logic          miss_clr, miss_inc;
  logic          stall_if, stall_d1, stall_d2;
  logic          flush_d1, flush_d2;

  // Mispredict overrides everything; otherwise each state applies its own
  // ID_STALL > miss > prediction > sequential ordering.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ready_pend_d = ready_pend_q;
    miss_clr     = 1'b0;
    miss_inc     = 1'b0;
    stall_if     = 1'b0;
    stall_d1     = 1'b0;
    stall_d2     = 1'b0;
    flush_d1     = 1'b0;
    flush_d2     = 1'b0;

    if (MISPREDICT) begin
      pc_d         = CORRECT_PC;
      flush_d1     = 1'b1;
      flush_d2     = 1'b1;
      ready_pend_d = 1'b0;
      miss_clr     = 1'b1;
      state_d      = ST_RECOVER;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ID_STALL) begin
            stall_if = 1'b1;
            stall_d1 = 1'b1;
            stall_d2 = 1'b1;
          end else if (IMISS) begin
            // Bubble into D1 while D2 drains; PC stays on the missing line.
            stall_if = 1'b1;
            flush_d1 = 1'b1;
            miss_clr = 1'b1;
            state_d  = ST_MISS;
          end else begin
            pc_d = PRED_TAKEN ? PRED_TARGET : next_seq_pc(pc_q);
          end
        end

        ST_MISS: begin
          stall_if = 1'b1;
          miss_inc = 1'b1;
          if (ID_STALL) begin
            stall_d1 = 1'b1;
            stall_d2 = 1'b1;
          end else begin
            flush_d1 = 1'b1;
          end
          if (IREADY) begin
            ready_pend_d = 1'b1;
          end
          // A refill that lands under a decode hold is remembered until the hold drops.
          if ((IREADY || ready_pend_q) && !ID_STALL) begin
            ready_pend_d = 1'b0;
            state_d      = ST_RUN;
          end
        end

        ST_RECOVER: begin
          flush_d1 = 1'b1;
          state_d  = ST_RUN;
          if (ID_STALL) begin
            stall_if = 1'b1;
            stall_d2 = 1'b1;
          end else begin
            pc_d = next_seq_pc(pc_q);
          end
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign miss_err_d = miss_err_q | (miss_inc && (miss_cnt >= MISS_LAST));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ready_pend_q <= 1'b0;
      miss_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ready_pend_q <= ready_pend_d;
      miss_err_q   <= miss_err_d;
    end
  end

  sat_counter #(.W(MW)) u_miss_cnt (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .clr_i  (miss_clr),
    .inc_i  (miss_inc),
    .q_o    (miss_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .clr_i  (1'b0),
    .inc_i  (stall_if),
    .q_o    (STALL_CNT)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .clr_i  (1'b0),
    .inc_i  (flush_d1 | flush_d2),
    .q_o    (FLUSH_CNT)
  );

  assign FETCH_PC = pc_q;
  assign STATE    = state_q;
  assign MISS_ERR = miss_err_q;
  assign STALL_IF = stall_if;
  assign STALL_D1 = stall_d1;
  assign STALL_D2 = stall_d2;
  assign FLUSH_D1 = flush_d1;
  assign FLUSH_D2 = flush_d2;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: stimulus queues expected values tagged
// with the cycle they apply to; a negedge monitor compares them.
module tb_fetch_seq_ctrl;

  localparam int CW = 7;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          IMISS, IREADY, ID_STALL, MISPREDICT, PRED_TAKEN;
  logic [31:0]   CORRECT_PC, PRED_TARGET;
  logic [31:0]   FETCH_PC;
  logic          STALL_IF, STALL_D1, STALL_D2, FLUSH_D1, FLUSH_D2;
  logic [1:0]    STATE;
  logic          MISS_ERR;
  logic [CW-1:0] STALL_CNT, FLUSH_CNT;

  fetch_seq_ctrl #(
    .RESET_PC     (32'hBFC0_0000),
    .MISS_TIMEOUT (64),
    .CNT_W        (CW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IMISS       (IMISS),
    .IREADY      (IREADY),
    .ID_STALL    (ID_STALL),
    .MISPREDICT  (MISPREDICT),
    .CORRECT_PC  (CORRECT_PC),
    .PRED_TAKEN  (PRED_TAKEN),
    .PRED_TARGET (PRED_TARGET),
    .FETCH_PC    (FETCH_PC),
    .STALL_IF    (STALL_IF),
    .STALL_D1    (STALL_D1),
    .STALL_D2    (STALL_D2),
    .FLUSH_D1    (FLUSH_D1),
    .FLUSH_D2    (FLUSH_D2),
    .STATE       (STATE),
    .MISS_ERR    (MISS_ERR),
    .STALL_CNT   (STALL_CNT),
    .FLUSH_CNT   (FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Signal selectors: 0 pc, 1 state, 2 {IF,D1,D2} stall, 3 {D1,D2} flush,
  // 4 miss_err, 5 stall_cnt, 6 flush_cnt.
  int          exp_cyc[$];
  int          exp_sig[$];
  logic [31:0] exp_val[$];
  string       exp_name[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit done   = 1'b0;
  int sc     = 0;
  int fc     = 0;

  function automatic logic [31:0] get_sig(input int s);
    case (s)
      0:       return FETCH_PC;
      1:       return {30'b0, STATE};
      2:       return {29'b0, STALL_IF, STALL_D1, STALL_D2};
      3:       return {30'b0, FLUSH_D1, FLUSH_D2};
      4:       return {31'b0, MISS_ERR};
      5:       return 32'(STALL_CNT);
      default: return 32'(FLUSH_CNT);
    endcase
  endfunction

  always @(negedge CLK) begin
    int i;
    logic [31:0] got;
    i = 0;
    while (i < exp_cyc.size()) begin
      if (exp_cyc[i] == cyc) begin
        got = get_sig(exp_sig[i]);
        n_chk++;
        if (got !== exp_val[i]) begin
          n_fail++;
          $display("FAIL %s: cycle %0d got %h, required %h", exp_name[i], cyc, got, exp_val[i]);
        end
        exp_cyc.delete(i); exp_sig.delete(i); exp_val.delete(i); exp_name.delete(i);
      end else if (done) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never sampled", exp_name[i], exp_cyc[i]);
        exp_cyc.delete(i); exp_sig.delete(i); exp_val.delete(i); exp_name.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic chk_push(input int dly, input int sig, input logic [31:0] v, input string nm);
    exp_cyc.push_back(cyc + dly);
    exp_sig.push_back(sig);
    exp_val.push_back(v);
    exp_name.push_back(nm);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Queues this cycle's stall/flush and the counters accumulated so far, then advances.
  task automatic cyc_chk(input logic [2:0] st, input logic [1:0] fl, input string nm);
    chk_push(0, 2, {29'b0, st}, {nm, "_stall"});
    chk_push(0, 3, {30'b0, fl}, {nm, "_flush"});
    chk_push(0, 5, sc, {nm, "_stall_cnt"});
    chk_push(0, 6, fc, {nm, "_flush_cnt"});
    if (st[2] && sc < 127) sc++;
    if ((|fl) && fc < 127) fc++;
    step();
  endtask

  initial begin
    RESET = 1'b0;
    IMISS = 0; IREADY = 0; ID_STALL = 0; MISPREDICT = 0; PRED_TAKEN = 0;
    CORRECT_PC = '0; PRED_TARGET = '0;
    step();

    chk_push(0, 0, 32'hBFC0_0000, "rst_pc");
    chk_push(0, 1, 0, "rst_state");
    chk_push(0, 4, 0, "rst_err");
    cyc_chk(3'b000, 2'b00, "rst");
    RESET = 1'b1;

    chk_push(0, 0, 32'hBFC0_0000, "seq_pc0");
    cyc_chk(3'b000, 2'b00, "seq0");
    chk_push(0, 0, 32'hBFC0_0004, "seq_pc1");
    cyc_chk(3'b000, 2'b00, "seq1");
    cyc_chk(3'b000, 2'b00, "seq2");
    chk_push(0, 0, 32'hBFC0_000C, "seq_pc3");

    PRED_TAKEN = 1; PRED_TARGET = 32'h0000_0400;
    chk_push(1, 0, 32'h0000_0400, "pred_pc");
    cyc_chk(3'b000, 2'b00, "pred");
    PRED_TARGET = 32'hFFFF_FFFC;
    chk_push(1, 0, 32'hFFFF_FFFC, "pred_top_pc");
    cyc_chk(3'b000, 2'b00, "pred2");
    PRED_TAKEN = 0;
    chk_push(1, 0, 32'h0000_0000, "wrap_pc");
    cyc_chk(3'b000, 2'b00, "wrap");
    PRED_TAKEN = 1; PRED_TARGET = 32'h0000_0100;
    cyc_chk(3'b000, 2'b00, "pred3");
    PRED_TAKEN = 0;

    IMISS = 1;
    chk_push(0, 0, 32'h100, "miss_pc");
    chk_push(1, 1, 1, "miss_enter");
    chk_push(1, 0, 32'h100, "miss_pc_hold");
    cyc_chk(3'b100, 2'b10, "run_imiss");
    IMISS = 0; ID_STALL = 1; IREADY = 1;
    chk_push(1, 1, 1, "miss_rdy_under_stall");
    cyc_chk(3'b111, 2'b00, "miss_hold1");
    IREADY = 0;
    chk_push(1, 1, 1, "miss_pend_stall");
    cyc_chk(3'b111, 2'b00, "miss_hold2");
    ID_STALL = 0;
    chk_push(1, 1, 0, "miss_exit");
    chk_push(1, 0, 32'h100, "miss_exit_pc");
    cyc_chk(3'b100, 2'b10, "miss_pend_exit");
    chk_push(1, 0, 32'h104, "post_miss_pc");
    cyc_chk(3'b000, 2'b00, "run_after_miss");

    MISPREDICT = 1; ID_STALL = 1; IMISS = 1; CORRECT_PC = 32'h200;
    chk_push(1, 0, 32'h200, "redirect_pc");
    chk_push(1, 1, 2, "redirect_state");
    cyc_chk(3'b000, 2'b11, "mispredict");
    MISPREDICT = 0; ID_STALL = 0; IMISS = 1;
    chk_push(1, 1, 0, "recover_exit");
    chk_push(1, 0, 32'h204, "recover_pc");
    cyc_chk(3'b000, 2'b10, "recover");
    IMISS = 0;
    chk_push(1, 0, 32'h208, "post_recover_pc");
    cyc_chk(3'b000, 2'b00, "run_after_recover");
    MISPREDICT = 1; CORRECT_PC = 32'h300;
    chk_push(1, 0, 32'h300, "redirect2_pc");
    cyc_chk(3'b000, 2'b11, "mispredict2");
    MISPREDICT = 0; ID_STALL = 1;
    chk_push(1, 0, 32'h300, "recover_stall_pc");
    chk_push(1, 1, 0, "recover_stall_exit");
    cyc_chk(3'b101, 2'b10, "recover_stall");
    ID_STALL = 0;
    chk_push(1, 0, 32'h304, "post_recover2_pc");
    cyc_chk(3'b000, 2'b00, "run_after_recover2");

    IMISS = 1;
    chk_push(1, 1, 1, "miss2_enter");
    cyc_chk(3'b100, 2'b10, "run_imiss2");
    IMISS = 0;
    for (int i = 1; i <= 63; i++) begin
      if (i == 63) chk_push(1, 4, 0, "err_before_timeout");
      cyc_chk(3'b100, 2'b10, "miss_wait");
    end
    chk_push(1, 4, 1, "err_at_timeout");
    chk_push(1, 1, 1, "still_miss");
    cyc_chk(3'b100, 2'b10, "miss_wait64");
    IREADY = 1;
    chk_push(1, 1, 0, "timeout_exit");
    chk_push(1, 4, 1, "err_sticky");
    cyc_chk(3'b100, 2'b10, "miss_ready");
    IREADY = 0;
    chk_push(0, 0, 32'h304, "timeout_exit_pc");
    chk_push(1, 0, 32'h308, "timeout_next_pc");
    chk_push(1, 4, 1, "err_sticky_run");
    cyc_chk(3'b000, 2'b00, "run_after_timeout");

    ID_STALL = 1;
    for (int i = 0; i < 60; i++) cyc_chk(3'b111, 2'b00, "run_stall");
    ID_STALL = 0;
    chk_push(0, 5, 32'd127, "stall_cnt_sat");
    chk_push(0, 0, 32'h308, "stall_pc_hold");

    IMISS = 1;
    cyc_chk(3'b100, 2'b10, "run_imiss3");
    IMISS = 0;
    #1 RESET = 1'b0;
    sc = 0; fc = 0;
    chk_push(0, 1, 0, "arst_state");
    chk_push(0, 0, 32'hBFC0_0000, "arst_pc");
    chk_push(0, 4, 0, "arst_err");
    chk_push(0, 5, 0, "arst_stall_cnt");
    chk_push(0, 6, 0, "arst_flush_cnt");
    chk_push(0, 2, 0, "arst_stall");
    chk_push(0, 3, 0, "arst_flush");
    step();
    RESET = 1'b1;
    chk_push(0, 0, 32'hBFC0_0000, "post_rst_pc");
    chk_push(1, 0, 32'hBFC0_0004, "post_rst_next_pc");
    cyc_chk(3'b000, 2'b00, "post_rst");
    step();
    step();

    done = 1'b1;
    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
